mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port `ram` between the `core` (port 0) and a second bus master such as the I/O or DMA unit (port 1). It sits between both requesters and the RAM's `read`/`write`/`addr`/`data_in`/`data_out` pins. It serialises accesses through a small FSM and grants in round-robin order when both ports request together. Each access completes with a one-cycle acknowledge and, for reads, returned data.

## Interface
- `ADDR_W`, 9: word-address width; matches the 512-word RAM.
- `DATA_W`, 32: data width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0` / `req1`  in  1  access request from port 0 / port 1.
- `we0` / `we1`  in  1  1 = write, 0 = read; sampled with the request.
- `addr0` / `addr1`  in  ADDR_W  word address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DATA_W  read data; valid in the cycle the matching ack is high.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `mem_read`  out  1  to RAM `read`.
- `mem_write`  out  1  to RAM `write`.
- `mem_addr`  out  ADDR_W  to RAM `addr`.
- `mem_data_in`  out  DATA_W  to RAM `data_in`.
- `mem_data_out`  in  DATA_W  from RAM `data_out`; valid on the cycle after `mem_read` is high.

## Operation
- **Requester contract:** hold `reqN`, `weN`, `addrN` and `wdataN` stable from assertion until `ackN`. A request still high in the cycle after `ackN` is treated as a new request.
- **FSM states:** IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port not granted last (`last_gnt` pointer).
  - On a grant: latch the winner's id, `we`, `addr` and `wdata` into internal registers, then go to ISSUE.
- **ISSUE**
  - Drive `mem_addr` and `mem_data_in` from the latched registers.
  - Assert `mem_write` if `we` = 1, otherwise `mem_read`, for exactly this cycle.
  - Next state: DONE for a write, WAIT for a read.
- **WAIT:** capture `mem_data_out` into the read-data register, then go to DONE.
- **DONE**
  - Pulse `ack` for the granted port only.
  - The granted port's `rdata` shows the captured word (read) or holds its previous value (write).
  - Update `last_gnt` to the granted id, then go to IDLE.
- **Rules that hold in every state**
  - `mem_read` and `mem_write` are never high together.
  - Both are 0 outside ISSUE.
  - `mem_addr` and `mem_data_in` hold their last-latched values outside ISSUE.
  - Requests arriving while `busy` wait; they are evaluated in the next IDLE cycle.
  - Exactly one ack per granted request. Never ack both ports in the same cycle.
  - The arbiter performs no arithmetic; address and data pass through unmodified. Address width is exact, with no wrap or range check.

## Timing
- **Reset values:** state = IDLE; `last_gnt` = 1, so port 0 wins the first tie; all outputs 0 (`ack*`, `busy`, `mem_read`, `mem_write`, `mem_addr`, `mem_data_in`, `rdata*`).
- **Write latency:** with `req` sampled high in IDLE at cycle t, ISSUE/`mem_write` is at t+1 and `ack` at t+2.
- **Read latency:** ISSUE/`mem_read` at t+1, WAIT/capture at t+2, `ack` with `rdata` at t+3.
- **Throughput:**
  - A port holding `req` high continuously with no competitor: one access every 3 cycles (write) or 4 cycles (read). DONE → IDLE costs one cycle.
  - Both ports requesting continuously: grants alternate 0,1,0,1…
- **`busy`:** high from t+1 through the ack cycle inclusive.
- **Reset mid-operation:** reset asserted in any state returns the FSM to IDLE on the next edge. No ack is issued for the aborted access. `mem_read`/`mem_write` are 0 from that edge, and `last_gnt` returns to 1.
- **Request dropped before ack:** violates the contract. The latched access still completes and acks.

## Test plan
- **Single write then read, port 0:** write `addr0`=0x005, `wdata0`=0xDEADBEEF; `ack0` arrives 2 cycles after the IDLE sample. Then read 0x005; `ack0` arrives 3 cycles after the sample with `rdata0`=0xDEADBEEF. `ack1` stays 0 throughout.
- **Simultaneous requests after reset:** port 0 writes 0x010←0x11111111 and port 1 writes 0x011←0x22222222 in the same cycle. Port 0 is granted first and port 1 next. Reading back gives 0x11111111 and 0x22222222.
- **Round-robin fairness:** both ports hold continuous read requests for 8 accesses. The ack sequence alternates 0,1,0,1…, with no port starved.
- **Cross-port coherence:** port 1 writes 0x1FF←0xA5A5A5A5 (top address). Port 0 then reads 0x1FF and gets `rdata0`=0xA5A5A5A5.
- **Reset during read:** assert reset in the WAIT state of a port 1 read. No `ack1` follows. All outputs are 0 the next cycle. A subsequent tie goes to port 0.
- **Exclusivity check (assertion over all scenarios):** `mem_read & mem_write` is never 1, and `ack0 & ack1` is never 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between two bus masters.
//
// Port 0 (core) and port 1 (I/O / DMA) raise reqN and hold weN/addrN/wdataN
// until ackN. An FSM serialises the accesses. Simultaneous requests are
// granted round-robin. Every access ends with a one-cycle ackN. For reads,
// rdataN carries the word in the same cycle as ackN.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   req0/1, we0/1          request and write-enable per port
//   addr0/1, wdata0/1      word address and write data per port
//   ack0/1, rdata0/1       completion pulse and read data per port
//   busy                   high whenever the FSM is not idle
//   mem_read, mem_write    RAM strobes, high only in the issue cycle
//   mem_addr, mem_data_in  RAM address and write data (last-latched values)
//   mem_data_out           RAM read data, valid the cycle after mem_read
module mem_arbiter #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;          // id of the port being served
    logic              last_gnt_q, last_gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              pick;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        busy_d      = busy_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        // On a tie the port not served last wins; otherwise the sole requester.
        pick        = (req0 && req1) ? ~last_gnt_q : req1;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    gnt_d       = pick;
                    we_d        = pick ? we1 : we0;
                    addr_d      = pick ? addr1 : addr0;
                    wdata_d     = pick ? wdata1 : wdata0;
                    // Strobes are registered, so they are set on the grant edge
                    // and appear during the issue cycle.
                    mem_write_d = we_d;
                    mem_read_d  = ~we_d;
                    busy_d      = 1'b1;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                if (we_q) begin
                    // Write: the ack goes straight to the done cycle.
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = StDone;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // RAM output is valid now; capture it for the granted port.
                if (gnt_q) begin
                    rdata1_d = mem_data_out;
                end else begin
                    rdata0_d = mem_data_out;
                end
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
                state_d = StDone;
            end
            StDone: begin
                last_gnt_d = gnt_q;
                busy_d     = 1'b0;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            busy_q      <= busy_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign busy        = busy_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM model, per-port transaction queues and a
// transaction-level reference model (grant edge, ack edge, expected memory).
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, busy, mem_read, mem_write;
    logic [31:0] rdata0, rdata1;
    logic [8:0]  mem_addr;
    logic [31:0] mem_data_in, mem_data_out;

    mem_arbiter #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
        .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data appears the cycle after mem_read.
    logic [31:0] ram [512];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) ram[i] <= '0;
            mem_data_out <= '0;
        end else begin
            if (mem_write) ram[mem_addr] <= mem_data_in;
            if (mem_read) mem_data_out <= ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_err = 0;
    int edge_n = 0;

    // Reference model state, in terms of edges since time zero.
    logic [31:0] ref_mem [512];
    int          m_grant, m_ack, m_free;
    logic        m_port, m_we, m_last;
    logic [8:0]  m_addr;
    logic [31:0] m_wdata, m_exp, m_rdata0, m_rdata1;

    txn_t q0[$];
    txn_t q1[$];
    logic pend0, pend1, rand_gaps;
    int   ack_log[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_step();
        logic w;
        edge_n++;
        if (reset) begin
            for (int i = 0; i < 512; i++) ref_mem[i] = '0;
            m_grant = -1; m_ack = -1; m_free = edge_n + 1;
            m_port = 1'b0; m_we = 1'b0; m_last = 1'b1;
            m_addr = '0; m_wdata = '0; m_rdata0 = '0; m_rdata1 = '0;
            pend0 = 1'b0; pend1 = 1'b0;
            q0.delete(); q1.delete();
            return;
        end
        if (edge_n == m_ack && !m_we) begin
            if (m_port) m_rdata1 = m_exp;
            else m_rdata0 = m_exp;
        end
        if (edge_n >= m_free && (req0 || req1)) begin
            w = (req0 && req1) ? !m_last : req1;
            m_port = w; m_last = w;
            m_we    = w ? we1 : we0;
            m_addr  = w ? addr1 : addr0;
            m_wdata = w ? wdata1 : wdata0;
            if (m_we) ref_mem[m_addr] = m_wdata;
            else m_exp = ref_mem[m_addr];
            m_grant = edge_n;
            m_ack   = edge_n + (m_we ? 1 : 2);
            m_free  = m_ack + 2;
        end
    endtask

    task automatic check_outputs();
        logic acked, in_op;
        acked = (edge_n == m_ack);
        in_op = (m_grant >= 0) && (edge_n >= m_grant) && (edge_n <= m_ack);
        check("ack0", ack0, acked && !m_port);
        check("ack1", ack1, acked && m_port);
        check("busy", busy, in_op);
        check("mem_write", mem_write, (edge_n == m_grant) && m_we);
        check("mem_read", mem_read, (edge_n == m_grant) && !m_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_data_in", mem_data_in, m_wdata);
        check("rdata0", rdata0, m_rdata0);
        check("rdata1", rdata1, m_rdata1);
        check("excl_mem", mem_read & mem_write, 0);
        check("excl_ack", ack0 & ack1, 0);
        if (ack0) ack_log.push_back(0);
        if (ack1) ack_log.push_back(1);
    endtask

    task automatic drive();
        txn_t t;
        if (edge_n == m_ack) begin
            if (m_port) pend1 = 1'b0;
            else pend0 = 1'b0;
        end
        if (!pend0 && q0.size() > 0 && !reset && (!rand_gaps || $urandom_range(0, 2) != 0)) begin
            t = q0.pop_front();
            req0 = 1'b1; we0 = t.we; addr0 = t.addr; wdata0 = t.data; pend0 = 1'b1;
        end else if (!pend0) begin
            req0 = 1'b0;
        end
        if (!pend1 && q1.size() > 0 && !reset && (!rand_gaps || $urandom_range(0, 2) != 0)) begin
            t = q1.pop_front();
            req1 = 1'b1; we1 = t.we; addr1 = t.addr; wdata1 = t.data; pend1 = 1'b1;
        end else if (!pend1) begin
            req1 = 1'b0;
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        drive();
    endtask

    task automatic drain(input int budget);
        int  b;
        logic done;
        b = budget;
        done = 1'b0;
        while (b > 0 && !done) begin
            run_cycle();
            b--;
            done = q0.size() == 0 && q1.size() == 0 && !pend0 && !pend1 && edge_n > m_ack;
        end
        check("drain_done", done, 1);
        run_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run_cycle();
        run_cycle();
        reset = 1'b0;
    endtask

    initial begin
        int   b;
        txn_t t;
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        rand_gaps = 1'b0;
        m_grant = -1; m_ack = -1; m_free = 0; m_last = 1'b1;
        m_port = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_exp = '0;
        m_rdata0 = '0; m_rdata1 = '0; pend0 = 0; pend1 = 0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        do_reset();
        run_cycle();

        // Port 0 write then read of the same word.
        q0.push_back('{we: 1'b1, addr: 9'h005, data: 32'hDEADBEEF});
        q0.push_back('{we: 1'b0, addr: 9'h005, data: 32'h0});
        drain(30);
        check("p0_readback", rdata0, 32'hDEADBEEF);

        // Simultaneous writes right after reset: port 0 first, then port 1.
        do_reset();
        ack_log.delete();
        q0.push_back('{we: 1'b1, addr: 9'h010, data: 32'h11111111});
        q1.push_back('{we: 1'b1, addr: 9'h011, data: 32'h22222222});
        drain(30);
        check("tie_n", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            check("tie_first", ack_log[0], 0);
            check("tie_second", ack_log[1], 1);
        end
        q0.push_back('{we: 1'b0, addr: 9'h010, data: 32'h0});
        q1.push_back('{we: 1'b0, addr: 9'h011, data: 32'h0});
        drain(30);
        check("tie_rd0", rdata0, 32'h11111111);
        check("tie_rd1", rdata1, 32'h22222222);

        // Round-robin: 4 back-to-back reads per port must alternate.
        ack_log.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{we: 1'b0, addr: 9'h010, data: 32'(i)});
            q1.push_back('{we: 1'b0, addr: 9'h011, data: 32'(i)});
        end
        drain(80);
        check("rr_n", ack_log.size(), 8);
        for (int i = 0; i < ack_log.size(); i++) check("rr_order", ack_log[i], i % 2);

        // Cross-port coherence at the top address.
        q1.push_back('{we: 1'b1, addr: 9'h1FF, data: 32'hA5A5A5A5});
        drain(30);
        q0.push_back('{we: 1'b0, addr: 9'h1FF, data: 32'h0});
        drain(30);
        check("xport_rd0", rdata0, 32'hA5A5A5A5);

        // Reset in the WAIT cycle of a port 1 read.
        q1.push_back('{we: 1'b0, addr: 9'h011, data: 32'h0});
        b = 20;
        while (b > 0 && !(m_port && m_grant >= 0 && !m_we && edge_n == m_grant + 1)) begin
            run_cycle();
            b--;
        end
        check("reached_wait", b > 0, 1);
        ack_log.delete();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) run_cycle();
        check("no_ack_after_abort", ack_log.size(), 0);
        q0.push_back('{we: 1'b1, addr: 9'h020, data: 32'h0BADF00D});
        q1.push_back('{we: 1'b1, addr: 9'h021, data: 32'hC0FFEE00});
        drain(30);
        check("post_rst_n", ack_log.size(), 2);
        if (ack_log.size() > 0) check("post_rst_first", ack_log[0], 0);

        // Random traffic with gaps, checked against the model every cycle.
        rand_gaps = 1'b1;
        for (int i = 0; i < 40; i++) begin
            t.we = 1'($urandom_range(0, 1));
            t.addr = ($urandom_range(0, 4) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
            t.data = $urandom;
            if (i % 2 == 0) q0.push_back(t);
            else q1.push_back(t);
        end
        drain(2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
